// File: rtl/trivium_lite_rx.sv
// ---------------------------------------------------------------------------
// trivium_lite_rx
//   Receive (decrypt) end of the trivium-lite byte link. A frame starts with
//   an 8-bit seed byte (in_sof) followed by ciphertext bytes. The block
//   regenerates the 3x16-bit keystream used by the transmitter and emits
//   plaintext = ciphertext ^ keystream byte.
//
// Parameters
//   WARMUP       keystream steps discarded after a seed load (0..255)
//   REJECT_SEED  when 1, seeds 8'h00 and 8'hFF are rejected
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous reset, active-high
//   in_data    seed or ciphertext byte
//   in_sof     in_data is the frame seed
//   in_eof     in_data is the last ciphertext byte of the frame
//   in_valid   input byte valid
//   in_ready   block can accept an input byte
//   out_data   plaintext byte
//   out_last   plaintext byte is the last of the frame
//   out_valid  plaintext valid
//   out_ready  consumer accepts the plaintext byte
//   busy       high in any state except IDLE
//   err        one-cycle pulse on a rejected seed or a dropped byte
// ---------------------------------------------------------------------------
module trivium_lite_rx #(
    parameter int unsigned WARMUP      = 16,
    parameter bit          REJECT_SEED = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_sof,
    input  logic       in_eof,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARM,
        ST_GEN,
        ST_WAIT_IN,
        ST_OUT
    } state_t;

    // Where a freshly loaded seed goes: straight to byte generation when
    // there is nothing to discard.
    localparam state_t     ST_AFTER_LOAD = (WARMUP == 0) ? ST_GEN : ST_WARM;
    localparam logic [7:0] WARM_LAST     = 8'(WARMUP - 1);

    state_t      r_state;
    logic [15:0] r_s1;
    logic [15:0] r_s2;
    logic [15:0] r_s3;
    logic [7:0]  r_ks;
    logic [7:0]  r_warm_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_out_data;
    logic        r_out_last;
    logic        r_out_valid;
    logic        r_err;

    // One keystream step, computed from the current registers.
    logic        w_ks_bit;
    logic [15:0] w_s1_step;
    logic [15:0] w_s2_step;
    logic [15:0] w_s3_step;

    assign w_ks_bit  = r_s1[0] ^ r_s2[0] ^ r_s3[0];
    assign w_s1_step = {r_s1[14:0], r_s2[0] ^ r_s3[1]};
    assign w_s2_step = {r_s2[14:0], r_s3[3] ^ r_s1[1]};
    assign w_s3_step = {r_s3[14:0], r_s1[5] ^ r_s2[2]};

    // Seed expansion from the byte currently on in_data.
    logic [15:0] w_s1_seed;
    logic [15:0] w_s2_seed;
    logic [15:0] w_s3_seed;
    logic        w_seed_bad;

    assign w_s1_seed  = {in_data, in_data};
    assign w_s2_seed  = {in_data, ~in_data[3:0], in_data[7:4]};
    assign w_s3_seed  = {in_data, in_data ^ 8'hA5};
    assign w_seed_bad = REJECT_SEED && ((in_data == 8'h00) || (in_data == 8'hFF));

    // NOTE: every register below is assigned with <= so all updates in a
    // cycle see the pre-edge values; the keystream step depends on that.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_s1        <= 16'h0001;
            r_s2        <= 16'h0002;
            r_s3        <= 16'h0003;
            r_ks        <= 8'h00;
            r_warm_cnt  <= 8'h00;
            r_bit_cnt   <= 3'd0;
            r_out_data  <= 8'h00;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // err is a pulse: cleared every cycle unless an event re-asserts it.
            r_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (!in_sof || w_seed_bad) begin
                            // Payload outside a frame, or an unusable seed.
                            r_err <= 1'b1;
                        end else begin
                            r_s1       <= w_s1_seed;
                            r_s2       <= w_s2_seed;
                            r_s3       <= w_s3_seed;
                            r_warm_cnt <= 8'h00;
                            r_bit_cnt  <= 3'd0;
                            r_state    <= ST_AFTER_LOAD;
                        end
                    end
                end

                ST_WARM: begin
                    r_s1 <= w_s1_step;
                    r_s2 <= w_s2_step;
                    r_s3 <= w_s3_step;
                    if (r_warm_cnt == WARM_LAST) begin
                        r_warm_cnt <= 8'h00;
                        r_state    <= ST_GEN;
                    end else begin
                        r_warm_cnt <= r_warm_cnt + 8'h01;
                    end
                end

                ST_GEN: begin
                    r_s1      <= w_s1_step;
                    r_s2      <= w_s2_step;
                    r_s3      <= w_s3_step;
                    // First generated bit ends up in bit 7.
                    r_ks      <= {r_ks[6:0], w_ks_bit};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_state <= ST_WAIT_IN;
                    end
                end

                ST_WAIT_IN: begin
                    if (in_valid) begin
                        if (in_sof) begin
                            // Resync: a new seed restarts the keystream.
                            if (w_seed_bad) begin
                                r_err   <= 1'b1;
                                r_state <= ST_IDLE;
                            end else begin
                                r_s1       <= w_s1_seed;
                                r_s2       <= w_s2_seed;
                                r_s3       <= w_s3_seed;
                                r_warm_cnt <= 8'h00;
                                r_bit_cnt  <= 3'd0;
                                r_state    <= ST_AFTER_LOAD;
                            end
                        end else begin
                            r_out_data  <= in_data ^ r_ks;
                            r_out_last  <= in_eof;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_OUT;
                        end
                    end
                end

                ST_OUT: begin
                    // out_data/out_last are only written in WAIT_IN, so they
                    // stay stable while the consumer stalls.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= r_out_last ? ST_IDLE : ST_GEN;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE) || (r_state == ST_WAIT_IN);
    assign busy      = (r_state != ST_IDLE);
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;
    assign err       = r_err;

endmodule

// File: tb/tb_trivium_lite_rx.sv
// ---------------------------------------------------------------------------
// tb_trivium_lite_rx
//   Self-checking bench for trivium_lite_rx. Two instances share one clock
//   and one set of stimulus signals: u_dut_w0 (WARMUP=0) and u_dut_w16
//   (WARMUP=16). 'sel' routes in_valid/out_ready to one instance and picks
//   which instance's outputs are observed. Expected plaintext comes from a
//   bit-serial keystream model kept in this file.
// ---------------------------------------------------------------------------
module tb_trivium_lite_rx;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_sof;
    logic       in_eof;
    logic       in_valid;
    logic       out_ready;
    logic       sel;

    logic       a_in_ready, a_out_last, a_out_valid, a_busy, a_err;
    logic [7:0] a_out_data;
    logic       b_in_ready, b_out_last, b_out_valid, b_busy, b_err;
    logic [7:0] b_out_data;

    logic       m_in_ready, m_out_last, m_out_valid, m_busy, m_err;
    logic [7:0] m_out_data;

    int total = 0;
    int bad   = 0;

    trivium_lite_rx #(.WARMUP(0), .REJECT_SEED(1'b1)) u_dut_w0 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .in_eof    (in_eof),
        .in_valid  (in_valid & ~sel),
        .in_ready  (a_in_ready),
        .out_data  (a_out_data),
        .out_last  (a_out_last),
        .out_valid (a_out_valid),
        .out_ready (out_ready & ~sel),
        .busy      (a_busy),
        .err       (a_err)
    );

    trivium_lite_rx #(.WARMUP(16), .REJECT_SEED(1'b1)) u_dut_w16 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .in_eof    (in_eof),
        .in_valid  (in_valid & sel),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_last  (b_out_last),
        .out_valid (b_out_valid),
        .out_ready (out_ready & sel),
        .busy      (b_busy),
        .err       (b_err)
    );

    assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign m_out_data  = sel ? b_out_data  : a_out_data;
    assign m_out_last  = sel ? b_out_last  : a_out_last;
    assign m_out_valid = sel ? b_out_valid : a_out_valid;
    assign m_busy      = sel ? b_busy      : a_busy;
    assign m_err       = sel ? b_err       : a_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=still running expected=finished");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Reference keystream: three 16-bit shift registers, one bit per step.
    // ------------------------------------------------------------------
    logic [15:0] m1, m2, m3;

    function automatic void mdl_load(input logic [7:0] s);
        m1 = {s, s};
        m2 = {s, ~s[3:0], s[7:4]};
        m3 = {s, s ^ 8'hA5};
    endfunction

    function automatic logic mdl_step();
        logic b, f1, f2, f3;
        b  = m1[0] ^ m2[0] ^ m3[0];
        f1 = m2[0] ^ m3[1];
        f2 = m3[3] ^ m1[1];
        f3 = m1[5] ^ m2[2];
        m1 = {m1[14:0], f1};
        m2 = {m2[14:0], f2};
        m3 = {m3[14:0], f3};
        return b;
    endfunction

    function automatic void mdl_warm(input int n);
        for (int i = 0; i < n; i++) begin
            void'(mdl_step());
        end
    endfunction

    function automatic logic [7:0] mdl_byte();
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            v = {v[6:0], mdl_step()};
        end
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Check / drive helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for in_ready, presents one byte for one handshake,
    // returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] d, input logic sof, input logic eof);
        int n;
        n = 0;
        while (!m_in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(m_in_ready), 32'd1);
        in_data  = d;
        in_sof   = sof;
        in_eof   = eof;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
    endtask

    // Counts negedges until in_ready is seen (bounded).
    task automatic wait_ready(output int n);
        n = 0;
        while (!m_in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Expects a plaintext byte, stalls the consumer 'hold' cycles, then
    // completes the output handshake.
    task automatic recv(input logic [7:0] exp_d, input logic exp_l, input int hold);
        int n;
        n = 0;
        while (!m_out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("out_valid", 32'(m_out_valid), 32'd1);
        check("out_data", 32'(m_out_data), 32'(exp_d));
        check("out_last", 32'(m_out_last), 32'(exp_l));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_data", 32'(m_out_data), 32'(exp_d));
            check("hold_valid", 32'(m_out_valid), 32'd1);
            check("hold_in_ready", 32'(m_in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_drop", 32'(m_out_valid), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int         n;
        logic [7:0] seed, p, k;

        rst       = 1'b1;
        sel       = 1'b0;
        in_data   = 8'h00;
        in_sof    = 1'b0;
        in_eof    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_in_ready", 32'(m_in_ready), 32'd1);
        check("rst_out_valid", 32'(m_out_valid), 32'd0);
        check("rst_out_data", 32'(m_out_data), 32'd0);
        check("rst_out_last", 32'(m_out_last), 32'd0);
        check("rst_busy", 32'(m_busy), 32'd0);
        check("rst_err", 32'(m_err), 32'd0);
        check("rst_b_busy", 32'(b_busy), 32'd0);

        // Seed 01, payload 00 with eof -> 82, last
        send(8'h01, 1'b1, 1'b0);
        check("t1_busy", 32'(m_busy), 32'd1);
        check("t1_gen_ready", 32'(m_in_ready), 32'd0);
        wait_ready(n);
        check("t1_seed_lat", 32'(n), 32'd8);
        send(8'h00, 1'b0, 1'b1);
        check("t1_out_lat", 32'(m_out_valid), 32'd1);
        recv(8'h82, 1'b1, 0);
        check("t1_idle_busy", 32'(m_busy), 32'd0);
        check("t1_idle_ready", 32'(m_in_ready), 32'd1);

        // Seed 01, payload 82 -> 00, consumer stalls 5 cycles; the second
        // byte must use the next keystream byte (nothing advanced in OUT).
        send(8'h01, 1'b1, 1'b0);
        wait_ready(n);
        send(8'h82, 1'b0, 1'b0);
        recv(8'h00, 1'b0, 5);
        wait_ready(n);
        check("t2_out_to_ready", 32'(n), 32'd8);
        mdl_load(8'h01);
        void'(mdl_byte());
        k = mdl_byte();
        send(k ^ 8'h5A, 1'b0, 1'b1);
        recv(8'h5A, 1'b1, 0);

        // Rejected seeds and a stray payload in IDLE
        send(8'h00, 1'b1, 1'b0);
        check("rej00_err", 32'(m_err), 32'd1);
        check("rej00_busy", 32'(m_busy), 32'd0);
        @(negedge clk);
        check("rej00_err_pulse", 32'(m_err), 32'd0);
        send(8'hFF, 1'b1, 1'b1);
        check("rejFF_err", 32'(m_err), 32'd1);
        check("rejFF_busy", 32'(m_busy), 32'd0);
        check("rejFF_ready", 32'(m_in_ready), 32'd1);
        @(negedge clk);
        check("rejFF_err_pulse", 32'(m_err), 32'd0);
        send(8'h33, 1'b0, 1'b0);
        check("drop_err", 32'(m_err), 32'd1);
        check("drop_no_out", 32'(m_out_valid), 32'd0);
        check("drop_busy", 32'(m_busy), 32'd0);
        @(negedge clk);
        check("drop_err_pulse", 32'(m_err), 32'd0);

        // WARMUP=16 instance: random seed, 32 random bytes
        sel  = 1'b1;
        seed = 8'($urandom_range(254, 1));
        mdl_load(seed);
        mdl_warm(16);
        send(seed, 1'b1, 1'b0);
        wait_ready(n);
        check("w16_seed_lat", 32'(n), 32'd24);
        for (int i = 0; i < 32; i++) begin
            p = 8'($urandom);
            k = mdl_byte();
            send(p ^ k, 1'b0, (i == 31));
            recv(p, (i == 31), int'($urandom_range(2, 0)));
            if (i < 31) begin
                wait_ready(n);
                check("w16_next_ready", 32'(n), 32'd8);
            end
        end
        check("w16_idle", 32'(m_busy), 32'd0);
        sel = 1'b0;
        @(negedge clk);

        // Mid-frame resync with seed 01 restarts the keystream
        seed = 8'($urandom_range(254, 1));
        send(seed, 1'b1, 1'b0);
        wait_ready(n);
        send(8'h01, 1'b1, 1'b0);
        check("resync_busy", 32'(m_busy), 32'd1);
        check("resync_gen", 32'(m_in_ready), 32'd0);
        wait_ready(n);
        check("resync_lat", 32'(n), 32'd8);
        send(8'h00, 1'b0, 1'b1);
        recv(8'h82, 1'b1, 0);

        // Mid-frame rejected seed returns to IDLE with err
        send(8'h01, 1'b1, 1'b0);
        wait_ready(n);
        send(8'hFF, 1'b1, 1'b0);
        check("resync_rej_err", 32'(m_err), 32'd1);
        check("resync_rej_busy", 32'(m_busy), 32'd0);
        @(negedge clk);

        // Reset during GEN
        send(8'h01, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstgen_valid", 32'(m_out_valid), 32'd0);
        check("rstgen_ready", 32'(m_in_ready), 32'd1);
        check("rstgen_busy", 32'(m_busy), 32'd0);

        // Reset during OUT
        send(8'h01, 1'b1, 1'b0);
        wait_ready(n);
        send(8'h00, 1'b0, 1'b0);
        check("rstout_pre", 32'(m_out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstout_valid", 32'(m_out_valid), 32'd0);
        check("rstout_ready", 32'(m_in_ready), 32'd1);
        check("rstout_busy", 32'(m_busy), 32'd0);

        // A following frame still decrypts correctly
        seed = 8'($urandom_range(254, 1));
        mdl_load(seed);
        p = 8'($urandom);
        k = mdl_byte();
        send(seed, 1'b1, 1'b0);
        wait_ready(n);
        send(p ^ k, 1'b0, 1'b1);
        recv(p, 1'b1, 1);
        check("post_rst_idle", 32'(m_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
